cbus_router: RTL and testbench

- Parametrised N-target CBus interconnect; successor to the fixed two-way RAM/device split.
- Sits between the CPU-side CBus master and NUM_TARGETS slaves (RAM, MMIO devices, boot ROM, ...).
- Decodes each request by base/mask region and locks the route for the whole burst.
- Terminates unmapped or illegal requests locally with an error response.

---
 rtl/cbus_router_if.sv | 31 +++
 rtl/cbus_router.sv | 200 ++++++++++++++++++++
 tb/tb_cbus_router.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbus_router_if.sv
// cbus_router_if -- CPU-side CBus request/response bundle.
//
// Carries one master request channel and its beat handshake.
//   master modport : drives valid/addr/wdata/burst/len/wstrobe,
//                    receives rdata/ready/last (the CPU side).
//   slave  modport : the mirror view, used by the router.
// Parameters ADDR_W / DATA_W must match the router instance using it.
interface cbus_router_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                valid;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [1:0]          burst;
    logic [7:0]          len;
    logic [DATA_W/8-1:0] wstrobe;
    logic [DATA_W-1:0]   rdata;
    logic                ready;
    logic                last;

    modport master (
        output valid, addr, wdata, burst, len, wstrobe,
        input  rdata, ready, last
    );

    modport slave (
        input  valid, addr, wdata, burst, len, wstrobe,
        output rdata, ready, last
    );
endinterface

// File: rtl/cbus_router.sv
// cbus_router -- parametrised N-target CBus interconnect.
//
// Decodes each master request against per-target base/mask regions
// (lowest index wins on overlap), locks the route for the whole burst and
// terminates unmapped or illegal requests locally with an error response.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   m (slave modport)   CPU-side request/response bundle
//   t_valid             one-hot target request
//   t_addr/t_burst/t_len  broadcast from the latched request
//   t_wdata/t_wstrobe   live master write data while routing
//   t_rdata/t_ready/t_last  packed per-target responses
//   dec_err             one-cycle pulse on the first error cycle
//   err_addr            address of the most recent error
//
// Optional feature macro: CBUS_ROUTER_PERF_EN
//   adds perf_cnt (per-target completed transactions, 32 bits each) and
//   perf_err (error entries); both saturate at 0xFFFFFFFF.
module cbus_router #(
    parameter int                            NUM_TARGETS = 4,
    parameter int                            ADDR_W      = 64,
    parameter int                            DATA_W      = 64,
    parameter logic [NUM_TARGETS*ADDR_W-1:0] TGT_BASE    = '0,
    parameter logic [NUM_TARGETS*ADDR_W-1:0] TGT_MASK    = '0,
    parameter logic [NUM_TARGETS-1:0]        TGT_SINGLE  = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    cbus_router_if.slave                  m,
    output logic [NUM_TARGETS-1:0]        t_valid,
    output logic [ADDR_W-1:0]             t_addr,
    output logic [DATA_W-1:0]             t_wdata,
    output logic [1:0]                    t_burst,
    output logic [7:0]                    t_len,
    output logic [DATA_W/8-1:0]           t_wstrobe,
    input  logic [NUM_TARGETS*DATA_W-1:0] t_rdata,
    input  logic [NUM_TARGETS-1:0]        t_ready,
    input  logic [NUM_TARGETS-1:0]        t_last,
    output logic                          dec_err,
    output logic [ADDR_W-1:0]             err_addr
`ifdef CBUS_ROUTER_PERF_EN
    ,
    output logic [NUM_TARGETS*32-1:0]     perf_cnt,
    output logic [31:0]                   perf_err
`endif
);

    localparam int SEL_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [SEL_W-1:0]    sel_q;
    logic [7:0]          beat_cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          burst_q;
    logic [7:0]          len_q;
    logic [DATA_W/8-1:0] wstrobe_q;

    logic                hit;
    logic [SEL_W-1:0]    hit_idx;
    logic                decode_ok;

    // Region decode on the live master address. Scanning from the highest
    // index down lets the lowest matching index overwrite, so it wins.
    // A single-beat-only target hit with len != 0 is treated as an error.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if ((m.addr & TGT_MASK[i*ADDR_W +: ADDR_W]) == TGT_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
        decode_ok = hit && !(TGT_SINGLE[hit_idx] && (m.len != 8'd0));
    end

    // Next-state logic. An abort (valid dropping) or a final beat ends a
    // routed burst; an error burst ends once len+1 beats have been given.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m.valid) begin
                    state_d = decode_ok ? ROUTE : ERR;
                end
            end
            ROUTE: begin
                if (!m.valid || (m.ready && m.last)) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (beat_cnt_q == len_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response and target-request muxing. Only the locked target ever sees
    // valid, and the master sees only that target's handshake. Ready/last
    // are qualified by master valid so an aborting cycle is not a beat.
    always_comb begin
        t_valid = '0;
        m.ready = 1'b0;
        m.last  = 1'b0;
        m.rdata = '0;
        case (state_q)
            ROUTE: begin
                t_valid[sel_q] = m.valid;
                m.ready        = m.valid & t_ready[sel_q];
                m.last         = m.valid & t_last[sel_q];
                m.rdata        = t_rdata[int'(sel_q)*DATA_W +: DATA_W];
            end
            ERR: begin
                m.ready = 1'b1;
                m.last  = (beat_cnt_q == len_q);
            end
            default: ;
        endcase
    end

    // Broadcast fields come from the latched request so a master address
    // change mid-burst cannot redirect the target. Write data and strobes
    // change per beat, so they follow the master live while routing.
    assign t_addr    = addr_q;
    assign t_burst   = burst_q;
    assign t_len     = len_q;
    assign t_wdata   = (state_q == ROUTE) ? m.wdata   : wdata_q;
    assign t_wstrobe = (state_q == ROUTE) ? m.wstrobe : wstrobe_q;

    // State, request latch, beat counter and error reporting. The request is
    // captured on the IDLE decode cycle; beat_cnt is cleared whenever the
    // next state is IDLE and otherwise counts beats without wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            beat_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            burst_q    <= '0;
            len_q      <= '0;
            wstrobe_q  <= '0;
            err_addr   <= '0;
            dec_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_err <= 1'b0;
            if (state_d == IDLE) begin
                beat_cnt_q <= '0;
            end else if (m.ready && (beat_cnt_q != 8'hFF)) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
            end
            if ((state_q == IDLE) && m.valid) begin
                addr_q    <= m.addr;
                wdata_q   <= m.wdata;
                burst_q   <= m.burst;
                len_q     <= m.len;
                wstrobe_q <= m.wstrobe;
                sel_q     <= hit_idx;
                if (!decode_ok) begin
                    err_addr <= m.addr;
                    dec_err  <= 1'b1;
                end
            end
        end
    end

`ifdef CBUS_ROUTER_PERF_EN
    // Saturating performance counters: completed routed transactions per
    // target, and the number of error-transaction entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt <= '0;
            perf_err <= '0;
        end else begin
            if ((state_q == ROUTE) && m.ready && m.last &&
                (perf_cnt[int'(sel_q)*32 +: 32] != 32'hFFFF_FFFF)) begin
                perf_cnt[int'(sel_q)*32 +: 32] <= perf_cnt[int'(sel_q)*32 +: 32] + 32'd1;
            end
            if ((state_q == IDLE) && m.valid && !decode_ok &&
                (perf_err != 32'hFFFF_FFFF)) begin
                perf_err <= perf_err + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cbus_router.sv
// tb_cbus_router -- randomized self-checking bench for cbus_router.
//
// Three targets: 0 = upper half (0x8000_0000/0x8000_0000), 1 = single-beat
// region 0x1000_0000/0xF000_0000, 2 = 0x0000_0000/0xC000_0000 (overlaps 1,
// so 1 must win). 0x4000_0000..0x7FFF_FFFF is unmapped.
module tb_cbus_router;

    localparam int NT = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic               clk;
    logic               rst_n;
    logic [NT-1:0]      t_valid;
    logic [AW-1:0]      t_addr;
    logic [DW-1:0]      t_wdata;
    logic [1:0]         t_burst;
    logic [7:0]         t_len;
    logic [DW/8-1:0]    t_wstrobe;
    logic [NT*DW-1:0]   t_rdata;
    logic [NT-1:0]      t_ready;
    logic [NT-1:0]      t_last;
    logic               dec_err;
    logic [AW-1:0]      err_addr;
`ifdef CBUS_ROUTER_PERF_EN
    logic [NT*32-1:0]   perf_cnt;
    logic [31:0]        perf_err;
`endif

    int tests_run;
    int tests_failed;

    // Reference view of the address map
    logic [31:0] reg_base   [NT] = '{32'h8000_0000, 32'h1000_0000, 32'h0000_0000};
    logic [31:0] reg_mask   [NT] = '{32'h8000_0000, 32'hF000_0000, 32'hC000_0000};
    bit          reg_single [NT] = '{1'b0, 1'b1, 1'b0};

    // Reference state tracked across transactions
    logic [31:0] exp_err_addr;
    int          exp_done [NT];
    int          exp_errs;

    cbus_router_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cbus_router #(
        .NUM_TARGETS (NT),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TGT_BASE    ({32'h0000_0000, 32'h1000_0000, 32'h8000_0000}),
        .TGT_MASK    ({32'hC000_0000, 32'hF000_0000, 32'h8000_0000}),
        .TGT_SINGLE  (3'b010)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m         (bus),
        .t_valid   (t_valid),
        .t_addr    (t_addr),
        .t_wdata   (t_wdata),
        .t_burst   (t_burst),
        .t_len     (t_len),
        .t_wstrobe (t_wstrobe),
        .t_rdata   (t_rdata),
        .t_ready   (t_ready),
        .t_last    (t_last),
        .dec_err   (dec_err),
        .err_addr  (err_addr)
`ifdef CBUS_ROUTER_PERF_EN
        ,
        .perf_cnt  (perf_cnt),
        .perf_err  (perf_err)
`endif
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if the observed value differs
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive every target with random responses; the addressed target's
    // last flag is forced to the value its burst plan calls for
    task automatic applyStimulus(input int sel, input bit last_v);
        for (int i = 0; i < NT; i++) begin
            t_ready[i]            = ($urandom_range(0, 3) != 0);
            t_last[i]             = 1'($urandom);
            t_rdata[i*DW +: DW]   = $urandom;
            if (i == sel) begin
                t_last[i] = last_v;
            end
        end
    endtask

    // Address map rule: first matching region wins; no match, or a
    // multi-beat request to a single-beat region, is an error
    function automatic void modelDecode(input logic [31:0] a, input logic [7:0] l,
                                        output int tgt, output bit err);
        tgt = -1;
        for (int i = 0; i < NT; i++) begin
            if ((tgt < 0) && ((a & reg_mask[i]) == reg_base[i])) begin
                tgt = i;
            end
        end
        err = (tgt < 0) || (reg_single[tgt] && (l != 8'd0));
    endfunction

    // One complete master transaction checked cycle by cycle
    task automatic runTrans(input logic [31:0] a, input logic [7:0] l, input bit mid_switch);
        int       tgt;
        bit       err;
        int       beats;
        int       cyc;
        bit       done;
        logic [1:0] bst;
        modelDecode(a, l, tgt, err);
        bst = 2'($urandom_range(0, 3));

        @(negedge clk);
        bus.valid   = 1'b1;
        bus.addr    = a;
        bus.len     = l;
        bus.burst   = bst;
        bus.wdata   = $urandom;
        bus.wstrobe = 4'($urandom);
        applyStimulus(-1, 1'b0);
        #1;
        checkOutput("decode_tvalid", 64'(t_valid), 64'd0);
        checkOutput("decode_ready", 64'(bus.ready), 64'd0);
        checkOutput("decode_dec_err", 64'(dec_err), 64'd0);

        beats = 0;
        cyc   = 0;
        done  = 1'b0;
        while (!done && (cyc < 600)) begin
            @(negedge clk);
            cyc++;
            bus.wdata   = $urandom;
            bus.wstrobe = 4'($urandom);
            if (mid_switch && (cyc == 2)) begin
                bus.addr = 32'h0000_0010;
            end
            applyStimulus(err ? -1 : tgt, (beats == int'(l)));
            #1;
            checkOutput("dec_err", 64'(dec_err), 64'(err && (cyc == 1)));
            checkOutput("err_addr", 64'(err_addr), 64'(err ? a : exp_err_addr));
            if (err) begin
                checkOutput("err_tvalid", 64'(t_valid), 64'd0);
                checkOutput("err_ready", 64'(bus.ready), 64'd1);
                checkOutput("err_rdata", 64'(bus.rdata), 64'd0);
                checkOutput("err_last", 64'(bus.last), 64'(beats == int'(l)));
                if (beats == int'(l)) begin
                    done = 1'b1;
                end
                beats++;
            end else begin
                checkOutput("route_tvalid", 64'(t_valid), 64'(1 << tgt));
                checkOutput("route_ready", 64'(bus.ready), 64'(t_ready[tgt]));
                checkOutput("route_last", 64'(bus.last), 64'(t_last[tgt]));
                checkOutput("route_rdata", 64'(bus.rdata), 64'(t_rdata[tgt*DW +: DW]));
                checkOutput("route_taddr", 64'(t_addr), 64'(a));
                checkOutput("route_tlen", 64'(t_len), 64'(l));
                checkOutput("route_tburst", 64'(t_burst), 64'(bst));
                checkOutput("route_twdata", 64'(t_wdata), 64'(bus.wdata));
                checkOutput("route_twstrobe", 64'(t_wstrobe), 64'(bus.wstrobe));
                if (t_ready[tgt]) begin
                    beats++;
                    if (t_last[tgt]) begin
                        done = 1'b1;
                    end
                end
            end
        end
        checkOutput("timeout", 64'(done), 64'd1);

        if (err) begin
            exp_err_addr = a;
            exp_errs++;
        end else begin
            exp_done[tgt]++;
        end

        @(negedge clk);
        bus.valid = 1'b0;
        applyStimulus(-1, 1'b0);
        #1;
        checkOutput("after_tvalid", 64'(t_valid), 64'd0);
        checkOutput("after_ready", 64'(bus.ready), 64'd0);
        checkOutput("after_last", 64'(bus.last), 64'd0);
    endtask

    // Master drops valid mid-burst: target valid must fall the same cycle
    task automatic runAbort();
        @(negedge clk);
        bus.valid = 1'b1;
        bus.addr  = 32'h8000_3000;
        bus.len   = 8'd3;
        applyStimulus(-1, 1'b0);
        @(negedge clk);
        applyStimulus(0, 1'b0);
        t_ready[0] = 1'b1;
        #1;
        checkOutput("abort_pre_tvalid", 64'(t_valid), 64'b001);
        @(negedge clk);
        bus.valid = 1'b0;
        applyStimulus(0, 1'b0);
        #1;
        checkOutput("abort_tvalid", 64'(t_valid), 64'd0);
        checkOutput("abort_ready", 64'(bus.ready), 64'd0);
    endtask

    // Reset asserted during beat 2 of a 4-beat burst
    task automatic runReset();
        @(negedge clk);
        bus.valid = 1'b1;
        bus.addr  = 32'h8000_2000;
        bus.len   = 8'd3;
        applyStimulus(-1, 1'b0);
        @(negedge clk);
        t_ready = '1;
        t_last  = '0;
        @(negedge clk);
        #1;
        checkOutput("rst_pre_tvalid", 64'(t_valid), 64'b001);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_tvalid", 64'(t_valid), 64'd0);
        checkOutput("rst_ready", 64'(bus.ready), 64'd0);
        checkOutput("rst_last", 64'(bus.last), 64'd0);
        checkOutput("rst_err_addr", 64'(err_addr), 64'd0);
        checkOutput("rst_taddr", 64'(t_addr), 64'd0);
        @(negedge clk);
        bus.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_err_addr = '0;
        exp_errs     = 0;
        for (int i = 0; i < NT; i++) begin
            exp_done[i] = 0;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_err_addr = '0;
        exp_errs     = 0;
        for (int i = 0; i < NT; i++) begin
            exp_done[i] = 0;
        end

        rst_n       = 1'b0;
        bus.valid   = 1'b1;
        bus.addr    = 32'h8000_0000;
        bus.wdata   = 32'hDEAD_BEEF;
        bus.burst   = 2'd1;
        bus.len     = 8'd2;
        bus.wstrobe = 4'hF;
        applyStimulus(-1, 1'b0);
        t_ready = '1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_tvalid", 64'(t_valid), 64'd0);
        checkOutput("reset_ready", 64'(bus.ready), 64'd0);
        checkOutput("reset_last", 64'(bus.last), 64'd0);
        checkOutput("reset_rdata", 64'(bus.rdata), 64'd0);
        checkOutput("reset_dec_err", 64'(dec_err), 64'd0);
        checkOutput("reset_err_addr", 64'(err_addr), 64'd0);
        checkOutput("reset_taddr", 64'(t_addr), 64'd0);
        checkOutput("reset_twdata", 64'(t_wdata), 64'd0);
        bus.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        runTrans(32'h8000_1000, 8'd3, 1'b0);
        runTrans(32'h8000_1000, 8'd3, 1'b1);
        runTrans(32'h4000_0000, 8'd1, 1'b0);
        runTrans(32'h1000_0040, 8'd2, 1'b0);
        runTrans(32'h1000_0040, 8'd0, 1'b0);
        runTrans(32'h1234_0000, 8'd0, 1'b0);
        runTrans(32'h2000_0100, 8'd4, 1'b0);
        runTrans(32'h5000_0000, 8'd255, 1'b0);
        runAbort();
        runTrans(32'h0000_0080, 8'd2, 1'b0);
        runReset();
        runTrans(32'h8000_4000, 8'd1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [7:0]  l;
            case ($urandom_range(0, 4))
                0:       a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFF);
                1:       a = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFF);
                2:       a = $urandom & 32'h3FFF_FFFF;
                3:       a = 32'h4000_0000 | ($urandom & 32'h3FFF_FFFF);
                default: a = $urandom;
            endcase
            l = 8'($urandom_range(0, 6));
            runTrans(a, l, 1'($urandom_range(0, 1)));
        end

`ifdef CBUS_ROUTER_PERF_EN
        @(negedge clk);
        for (int i = 0; i < NT; i++) begin
            checkOutput("perf_cnt", 64'(perf_cnt[i*32 +: 32]), 64'(exp_done[i]));
        end
        checkOutput("perf_err", 64'(perf_err), 64'(exp_errs));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
